// File: rtl/demux_1t8_32_buf.sv
// Buffered 1-to-8 demultiplexer: one valid/ready input steered into eight single-entry
// holding registers, each drained by its own consumer. Broadcast option: DEMUX_BCAST_EN.
module demux_1t8_32_buf #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_sel,
  input  logic [WIDTH-1:0]     in_data,
`ifdef DEMUX_BCAST_EN
  input  logic                 in_bcast,
`endif
  output logic [7:0]           out_valid,
  input  logic [7:0]           out_ready,
  output logic [8*WIDTH-1:0]   out_data,
  output logic [3:0]           occ
);

  localparam int LANES = 8;

  logic [LANES-1:0] full;
  logic [LANES-1:0] lane_free;
  logic [LANES-1:0] load;
  logic [LANES-1:0] full_nxt;
  logic [WIDTH-1:0] data_q [LANES];
  logic             accept;

  // A lane can take a word if it is empty or is being drained on this same edge.
  assign lane_free = ~full | out_ready;

`ifdef DEMUX_BCAST_EN
  assign in_ready = in_bcast ? (&lane_free) : lane_free[in_sel];
`else
  assign in_ready = lane_free[in_sel];
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load = '0;
    if (accept) begin
`ifdef DEMUX_BCAST_EN
      if (in_bcast) load = '1;
      else          load[in_sel] = 1'b1;
`else
      load[in_sel] = 1'b1;
`endif
    end
    // Drain clears, load sets; a same-edge drain+load leaves the lane full with the new word.
    full_nxt = (full & ~out_ready) | load;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      occ  <= '0;
    end else begin
      full <= full_nxt;
      occ  <= 4'($countones(full_nxt));
    end
  end

  // NOTE: the holding registers are reset because out_data must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (load[k]) data_q[k] <= in_data;
      end
    end
  end

  assign out_valid = full;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign out_data[g*WIDTH +: WIDTH] = data_q[g];
  end

endmodule

// File: tb/tb_demux_1t8_32_buf.sv
// Self-checking bench for demux_1t8_32_buf: directed scenarios plus randomized traffic
// compared against per-lane queues of accepted words.
module tb_demux_1t8_32_buf;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_sel;
  logic [31:0]  in_data;
  logic         bcast;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [255:0] out_data;
  logic [3:0]   occ;

  int n_checks = 0;
  int n_pass   = 0;
  logic seen_ready;

  logic [31:0] q [8][$];
  logic [31:0] last_word [8];

  always #5 clk = ~clk;

  demux_1t8_32_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (bcast),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
  );

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic model_ready();
    if (bcast) begin
      for (int k = 0; k < 8; k++)
        if (q[k].size() != 0 && !out_ready[k]) return 1'b0;
      return 1'b1;
    end
    return (q[in_sel].size() == 0) || out_ready[in_sel];
  endfunction

  task automatic check_outputs(input string tag);
    logic [7:0]   ev;
    logic [255:0] ed;
    int           cnt;
    ev = '0; ed = '0; cnt = 0;
    for (int k = 0; k < 8; k++) begin
      ev[k] = (q[k].size() != 0);
      ed[k*32 +: 32] = ev[k] ? q[k][0] : last_word[k];
      if (ev[k]) cnt++;
    end
    check({tag, ".out_valid"}, out_valid, ev);
    check({tag, ".out_data"}, out_data, ed);
    check({tag, ".occ"}, occ, cnt);
  endtask

  function automatic logic [31:0] lane(input int k);
    return out_data[k*32 +: 32];
  endfunction

  // Called at a negedge: apply inputs, check in_ready, clock once, update model, check outputs.
  task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] d,
                       input logic [7:0] r, input logic b, output logic acc);
    logic exp_r;
    in_valid = v; in_sel = s; in_data = d; out_ready = r; bcast = b;
    #1;
    exp_r = model_ready();
    seen_ready = in_ready;
    check("in_ready", in_ready, exp_r);
    acc = v && exp_r;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      if (q[k].size() != 0 && r[k]) last_word[k] = q[k].pop_front();
      if (acc && (b || s == 3'(k))) begin
        q[k].push_back(d);
        last_word[k] = d;
      end
    end
    @(negedge clk);
    check_outputs("cycle");
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; bcast = 1'b0; out_ready = '0;
    #1;
    for (int k = 0; k < 8; k++) begin
      q[k].delete();
      last_word[k] = '0;
    end
    check("rst.out_valid", out_valid, 8'h00);
    check("rst.occ", occ, 4'd0);
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_data", out_data, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    logic pend;
    logic [2:0]  rs;
    logic [31:0] rd;
    logic        rv, rb;

    in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0; bcast = 0;
    for (int k = 0; k < 8; k++) last_word[k] = '0;
    @(negedge clk);
    apply_reset();

    // Single route: first accept on the first edge after reset release.
    drive(1, 3'd3, 32'hDEADBEEF, 8'h00, 0, acc);
    check("single.valid", out_valid, 8'h08);
    check("single.data", lane(3), 32'hDEADBEEF);
    check("single.occ", occ, 4'd1);
    drive(0, 3'd0, 32'h0, 8'h08, 0, acc);
    check("single.drain", out_valid, 8'h00);
    check("single.keep", lane(3), 32'hDEADBEEF);

    // Reset mid-operation with lanes 2 and 5 full.
    drive(1, 3'd2, 32'hAAAA0002, 8'h00, 0, acc);
    drive(1, 3'd5, 32'hAAAA0005, 8'h00, 0, acc);
    check("pre_rst.valid", out_valid, 8'h24);
    apply_reset();

    // Back-pressure on lane 6 while other lanes stay open.
    drive(1, 3'd6, 32'h11111111, 8'h00, 0, acc);
    drive(1, 3'd6, 32'h22222222, 8'h00, 0, acc);
    check("bp.blocked", seen_ready, 1'b0);
    drive(1, 3'd6, 32'h22222222, 8'h00, 0, acc);
    check("bp.still_blocked", seen_ready, 1'b0);
    check("bp.old_word", lane(6), 32'h11111111);
    drive(1, 3'd6, 32'h22222222, 8'h40, 0, acc);
    check("bp.released", seen_ready, 1'b1);
    check("bp.new_word", lane(6), 32'h22222222);
    check("bp.lane6_valid", out_valid, 8'h40);
    drive(1, 3'd1, 32'h33333333, 8'h00, 0, acc);
    check("bp.sel1", lane(1), 32'h33333333);
    drive(0, 3'd0, 32'h0, 8'hFF, 0, acc);

    // Streaming into lane 0 with its consumer always ready.
    for (int i = 1; i <= 4; i++) begin
      drive(1, 3'd0, 32'(i), 8'h01, 0, acc);
      check("stream.ready", seen_ready, 1'b1);
      check("stream.data", lane(0), 32'(i));
      check("stream.occ", occ, 4'd1);
    end
    drive(0, 3'd0, 32'h0, 8'h01, 0, acc);
    check("stream.end_occ", occ, 4'd0);

    // Round robin fill of every lane, then a ninth word sees back-pressure.
    for (int k = 0; k < 8; k++) drive(1, 3'(k), 32'(k + 100), 8'h00, 0, acc);
    check("rr.valid", out_valid, 8'hFF);
    check("rr.occ", occ, 4'd8);
    for (int k = 0; k < 8; k++) check("rr.data", lane(k), 32'(k + 100));
    drive(1, 3'($urandom_range(7)), 32'd999, 8'h00, 0, acc);
    check("rr.ninth", seen_ready, 1'b0);
    drive(0, 3'd0, 32'h0, 8'hFF, 0, acc);

`ifdef DEMUX_BCAST_EN
    drive(1, 3'd4, 32'h44444444, 8'h00, 0, acc);
    drive(1, 3'd0, 32'hCAFE0000, 8'h00, 1, acc);
    check("bc.blocked", seen_ready, 1'b0);
    drive(1, 3'd0, 32'hCAFE0000, 8'h10, 1, acc);
    check("bc.accepted", seen_ready, 1'b1);
    check("bc.valid", out_valid, 8'hFF);
    check("bc.occ", occ, 4'd8);
    for (int k = 0; k < 8; k++) check("bc.data", lane(k), 32'hCAFE0000);
    drive(0, 3'd0, 32'h0, 8'hFF, 0, acc);
`endif

    // Randomized traffic; a refused word is held stable until accepted.
    pend = 1'b0; rv = 0; rs = 0; rd = 0; rb = 0;
    for (int i = 0; i < 500; i++) begin
      if (!pend) begin
        rv = ($urandom_range(3) != 0);
        rs = 3'($urandom);
        rd = $urandom;
`ifdef DEMUX_BCAST_EN
        rb = ($urandom_range(7) == 0);
`endif
      end
      drive(rv, rs, rd, 8'($urandom), rb, acc);
      pend = rv && !acc;
    end

    @(negedge clk);
    apply_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
